// File: rtl/cordic_ln_plus.sv
// cordic_ln_plus: pipelined natural log, unsigned Q(WII).16 in, signed Q(WOI).16 out.
// Optional build macro CORDIC_LN_ZERO_FLAG_EN adds the registered zero_err output.
module cordic_ln_plus #(
    parameter int WII      = 16,
    parameter int WOI      = 16,
    parameter int WOF      = 16,
    parameter int PIPELINE = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WII+15:0]           iData,
    input  logic                      pre_vaild,
    output logic signed [WOI+WOF-1:0] ln,
    output logic                      post_vaild
`ifdef CORDIC_LN_ZERO_FLAG_EN
    ,
    output logic                      zero_err
`endif
);

    localparam int DW      = WII + 16;
    localparam int OW      = WOI + WOF;
    localparam int CW      = 32;
    localparam int PW      = $clog2(DW);
    localparam int EW      = PW + 2;
    localparam int SW      = OW + 2;
    localparam int LN2_Q16 = 45426;

    typedef logic signed [CW-1:0] cw_t;
    typedef logic signed [EW-1:0] e_t;
    typedef logic signed [SW-1:0] sw_t;

    localparam logic signed [OW-1:0] LN_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] LN_MIN = {1'b1, {(OW-1){1'b0}}};

    function automatic int unsigned shift_of(input int unsigned k);
        if (k < 4)       return k + 1;
        else if (k < 14) return k;
        else             return k - 1;
    endfunction

    function automatic int angle_of(input int unsigned s);
        case (s)
            1:       return 35999;
            2:       return 16739;
            3:       return 8235;
            4:       return 4101;
            5:       return 2049;
            6:       return 1024;
            7:       return 512;
            8:       return 256;
            9:       return 128;
            10:      return 64;
            11:      return 32;
            12:      return 16;
            13:      return 8;
            default: return 4;
        endcase
    endfunction

    logic [PW-1:0] msb_pos;
    logic [16:0]   mant;
    logic          in_zero;

    cw_t  x_q  [0:PIPELINE-1];
    cw_t  x_d  [0:PIPELINE-1];
    cw_t  y_q  [0:PIPELINE-1];
    cw_t  y_d  [0:PIPELINE-1];
    cw_t  z_q  [0:PIPELINE];
    cw_t  z_d  [0:PIPELINE];
    e_t   e_q  [0:PIPELINE];
    e_t   e_d  [0:PIPELINE];
    logic zf_q [0:PIPELINE];
    logic zf_d [0:PIPELINE];
    logic v_q  [0:PIPELINE];
    logic v_d  [0:PIPELINE];

    sw_t                 sum;
    logic signed [OW-1:0] ln_sat;
    logic signed [OW-1:0] ln_q, ln_d;
    logic                 post_vaild_q, post_vaild_d;
`ifdef CORDIC_LN_ZERO_FLAG_EN
    logic                 zero_err_q, zero_err_d;
`endif

    // Range reduction: normalise the operand to m in [1,2) and keep the exponent.
    always_comb begin
        msb_pos = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (iData[i]) msb_pos = PW'(i);
        end
        in_zero = (iData == '0);
        if (msb_pos < PW'(16)) mant = 17'(iData << (PW'(16) - msb_pos));
        else                   mant = 17'(iData >> (msb_pos - PW'(16)));
    end

    always_comb begin
        x_d[0]  = cw_t'(mant) + cw_t'(65536);
        y_d[0]  = cw_t'(mant) - cw_t'(65536);
        z_d[0]  = '0;
        e_d[0]  = e_t'(msb_pos) - e_t'(16);
        zf_d[0] = in_zero;
        v_d[0]  = pre_vaild;

        // y == 0 means the residual angle is exactly zero, so the stage holds;
        // this keeps exact powers of two free of CORDIC dither.
        for (int unsigned k = 0; k < PIPELINE; k++) begin
            v_d[k+1]  = v_q[k];
            e_d[k+1]  = e_q[k];
            zf_d[k+1] = zf_q[k];
            if (y_q[k] == '0)       z_d[k+1] = z_q[k];
            else if (!y_q[k][CW-1]) z_d[k+1] = z_q[k] + cw_t'(angle_of(shift_of(k)));
            else                    z_d[k+1] = z_q[k] - cw_t'(angle_of(shift_of(k)));
        end

        for (int unsigned k = 0; k + 1 < PIPELINE; k++) begin
            if (y_q[k] == '0) begin
                x_d[k+1] = x_q[k];
                y_d[k+1] = y_q[k];
            end else if (!y_q[k][CW-1]) begin
                x_d[k+1] = x_q[k] - (y_q[k] >>> shift_of(k));
                y_d[k+1] = y_q[k] - (x_q[k] >>> shift_of(k));
            end else begin
                x_d[k+1] = x_q[k] + (y_q[k] >>> shift_of(k));
                y_d[k+1] = y_q[k] + (x_q[k] >>> shift_of(k));
            end
        end
    end

    always_comb begin
        sum = (sw_t'(z_q[PIPELINE]) <<< 1) + sw_t'(e_q[PIPELINE]) * sw_t'(LN2_Q16);
        if (zf_q[PIPELINE])          ln_sat = LN_MIN;
        else if (sum > sw_t'(LN_MAX)) ln_sat = LN_MAX;
        else if (sum < sw_t'(LN_MIN)) ln_sat = LN_MIN;
        else                          ln_sat = OW'(sum);

        post_vaild_d = v_q[PIPELINE];
        ln_d         = v_q[PIPELINE] ? ln_sat : ln_q;
`ifdef CORDIC_LN_ZERO_FLAG_EN
        zero_err_d   = v_q[PIPELINE] & zf_q[PIPELINE];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= PIPELINE; i++) v_q[i] <= 1'b0;
            ln_q         <= '0;
            post_vaild_q <= 1'b0;
`ifdef CORDIC_LN_ZERO_FLAG_EN
            zero_err_q   <= 1'b0;
`endif
        end else begin
            v_q          <= v_d;
            ln_q         <= ln_d;
            post_vaild_q <= post_vaild_d;
`ifdef CORDIC_LN_ZERO_FLAG_EN
            zero_err_q   <= zero_err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        x_q  <= x_d;
        y_q  <= y_d;
        z_q  <= z_d;
        e_q  <= e_d;
        zf_q <= zf_d;
    end

    assign ln         = ln_q;
    assign post_vaild = post_vaild_q;
`ifdef CORDIC_LN_ZERO_FLAG_EN
    assign zero_err   = zero_err_q;
`endif

endmodule

// File: tb/tb_cordic_ln_plus.sv
// Directed and streamed checks of cordic_ln_plus: latency, exact points, zero input,
// hold behaviour, mid-stream reset and a random stream against an algorithmic model.
module tb_cordic_ln_plus;

    localparam int WII = 16;
    localparam int WOI = 16;
    localparam int WOF = 16;
    localparam int P   = 16;
    localparam int DW  = WII + 16;
    localparam int LAT = P + 2;
    localparam longint LN_MIN = -64'sd2147483648;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      pre_vaild = 1'b0;
    logic [DW-1:0]             iData = '0;
    logic signed [WOI+WOF-1:0] ln;
    logic                      post_vaild;
`ifdef CORDIC_LN_ZERO_FLAG_EN
    logic                      zero_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    longint out_ln[$];
    int     out_cyc[$];
    logic   out_zf[$];
    longint in_x[$];
    int     in_cyc[$];

    int sched [16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
    int atab  [15] = '{0, 35999, 16739, 8235, 4101, 2049, 1024, 512, 256, 128, 64, 32, 16, 8, 4};

    cordic_ln_plus #(.WII(WII), .WOI(WOI), .WOF(WOF), .PIPELINE(P)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .iData(iData),
        .pre_vaild(pre_vaild),
        .ln(ln),
        .post_vaild(post_vaild)
`ifdef CORDIC_LN_ZERO_FLAG_EN
        ,
        .zero_err(zero_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (post_vaild === 1'b1) begin
            out_ln.push_back(longint'(ln));
            out_cyc.push_back(cyc);
`ifdef CORDIC_LN_ZERO_FLAG_EN
            out_zf.push_back(zero_err);
`else
            out_zf.push_back(1'b0);
`endif
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Hyperbolic-vectoring log model built from the algorithm description.
    function automatic longint model_ln(input longint x);
        longint p, e, m, xx, yy, zz, nx, ny, r;
        int s;
        if (x == 0) return LN_MIN;
        p = 0;
        for (int i = 0; i < DW; i++) if (x[i]) p = i;
        e = p - 16;
        m = (p < 16) ? (x << (16 - p)) : (x >> (p - 16));
        xx = m + 65536;
        yy = m - 65536;
        zz = 0;
        for (int k = 0; k < P; k++) begin
            s = sched[k];
            nx = xx;
            ny = yy;
            if (yy > 0) begin
                nx = xx - (yy >>> s);
                ny = yy - (xx >>> s);
                zz = zz + atab[s];
            end else if (yy < 0) begin
                nx = xx + (yy >>> s);
                ny = yy + (xx >>> s);
                zz = zz - atab[s];
            end
            xx = nx;
            yy = ny;
        end
        r = 2 * zz + e * 45426;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < LN_MIN) r = LN_MIN;
        return r;
    endfunction

    function automatic longint absl(input longint a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic clear_q;
        out_ln.delete();
        out_cyc.delete();
        out_zf.delete();
        in_x.delete();
        in_cyc.delete();
    endtask

    task automatic drive(input logic v, input longint x);
        @(negedge clk);
        pre_vaild = v;
        iData = DW'(x);
        if (v) begin
            in_x.push_back(x);
            in_cyc.push_back(cyc);
        end
    endtask

    task automatic wait_out(input int n);
        int budget;
        budget = LAT + 40;
        drive(1'b0, 0);
        while (out_ln.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        pre_vaild = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (post_vaild !== 1'b0) begin
            errors++;
            $display("FAIL reset_post_vaild: got %b expected 0", post_vaild);
        end
        checks++;
        if (ln !== '0) begin
            errors++;
            $display("FAIL reset_ln: got %0d expected 0", ln);
        end
`ifdef CORDIC_LN_ZERO_FLAG_EN
        checks++;
        if (zero_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero_err: got %b expected 0", zero_err);
        end
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (post_vaild !== 1'b0) begin
            errors++;
            $display("FAIL idle_post_vaild: got %b expected 0", post_vaild);
        end
        clear_q();
    endtask

    task automatic test_unity;
        clear_q();
        drive(1'b1, 65536);
        wait_out(1);
        checks++;
        if (out_ln.size() != 1) begin
            errors++;
            $display("FAIL unity_count: got %0d outputs expected 1", out_ln.size());
        end
        if (out_ln.size() >= 1) begin
            checks++;
            if (out_cyc[0] - in_cyc[0] != LAT) begin
                errors++;
                $display("FAIL unity_latency: got %0d cycles expected %0d", out_cyc[0] - in_cyc[0], LAT);
            end
            checks++;
            if (out_ln[0] != 0) begin
                errors++;
                $display("FAIL unity_ln: got %0d expected 0", out_ln[0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        clear_q();
        drive(1'b1, 131072);
        drive(1'b1, 32768);
        wait_out(2);
        checks++;
        if (out_ln.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs expected 2", out_ln.size());
        end
        if (out_ln.size() >= 2) begin
            checks++;
            if (absl(out_ln[0] - 45426) > 4) begin
                errors++;
                $display("FAIL b2b_ln_two: got %0d expected 45426 +/-4", out_ln[0]);
            end
            checks++;
            if (absl(out_ln[1] + 45426) > 4) begin
                errors++;
                $display("FAIL b2b_ln_half: got %0d expected -45426 +/-4", out_ln[1]);
            end
            checks++;
            if (out_cyc[1] - out_cyc[0] != 1) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d cycles expected 1", out_cyc[1] - out_cyc[0]);
            end
        end
    endtask

    task automatic test_special_points;
        clear_q();
        drive(1'b1, 178145);
        drive(1'b1, 1);
        wait_out(2);
        checks++;
        if (out_ln.size() != 2) begin
            errors++;
            $display("FAIL special_count: got %0d outputs expected 2", out_ln.size());
        end
        if (out_ln.size() >= 2) begin
            checks++;
            if (absl(out_ln[0] - model_ln(178145)) > 4) begin
                errors++;
                $display("FAIL ln_e_model: got %0d expected %0d +/-4", out_ln[0], model_ln(178145));
            end
            checks++;
            if (absl(out_ln[0] - 65536) > 32) begin
                errors++;
                $display("FAIL ln_e_ideal: got %0d expected 65536 +/-32", out_ln[0]);
            end
            checks++;
            if (absl(out_ln[1] + 726817) > 4) begin
                errors++;
                $display("FAIL ln_min_lsb: got %0d expected -726817 +/-4", out_ln[1]);
            end
        end
    endtask

    task automatic test_zero;
        clear_q();
        drive(1'b1, 65536);
        drive(1'b1, 0);
        wait_out(2);
        checks++;
        if (out_ln.size() != 2) begin
            errors++;
            $display("FAIL zero_count: got %0d outputs expected 2", out_ln.size());
        end
        if (out_ln.size() >= 2) begin
            checks++;
            if (out_ln[0] != 0) begin
                errors++;
                $display("FAIL zero_pre_ln: got %0d expected 0", out_ln[0]);
            end
            checks++;
            if (out_ln[1] != LN_MIN) begin
                errors++;
                $display("FAIL zero_ln: got %0d expected %0d", out_ln[1], LN_MIN);
            end
`ifdef CORDIC_LN_ZERO_FLAG_EN
            checks++;
            if (out_zf[0] !== 1'b0) begin
                errors++;
                $display("FAIL zero_err_nonzero: got %b expected 0", out_zf[0]);
            end
            checks++;
            if (out_zf[1] !== 1'b1) begin
                errors++;
                $display("FAIL zero_err_flag: got %b expected 1", out_zf[1]);
            end
`endif
        end
    endtask

    task automatic test_hold;
        repeat (5) @(negedge clk);
        checks++;
        if (post_vaild !== 1'b0) begin
            errors++;
            $display("FAIL hold_post_vaild: got %b expected 0", post_vaild);
        end
        checks++;
        if (longint'(ln) != LN_MIN) begin
            errors++;
            $display("FAIL hold_ln: got %0d expected %0d", ln, LN_MIN);
        end
`ifdef CORDIC_LN_ZERO_FLAG_EN
        checks++;
        if (zero_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_zero_err: got %b expected 0", zero_err);
        end
`endif
    endtask

    task automatic test_random_stream;
        int n;
        real ideal;
        clear_q();
        for (int i = 0; i < 1000; i++) begin
            longint x;
            int gap;
            x = longint'($urandom) >> $urandom_range(0, 31);
            if (i == 0) x = 64'h0000_0000_FFFF_FFFF;
            if (x == 0) x = 1;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            repeat (gap) drive(1'b0, 0);
            drive(1'b1, x);
        end
        wait_out(1000);
        checks++;
        if (out_ln.size() != in_x.size()) begin
            errors++;
            $display("FAIL random_count: got %0d outputs expected %0d", out_ln.size(), in_x.size());
        end
        n = (out_ln.size() < in_x.size()) ? out_ln.size() : in_x.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (absl(out_ln[i] - model_ln(in_x[i])) > 4) begin
                errors++;
                $display("FAIL random_model[%0d]: x=%0d got %0d expected %0d +/-4", i, in_x[i], out_ln[i], model_ln(in_x[i]));
            end
            ideal = $ln(real'(in_x[i]) / 65536.0) * 65536.0;
            checks++;
            if (real'(out_ln[i]) - ideal > 32.0 || ideal - real'(out_ln[i]) > 32.0) begin
                errors++;
                $display("FAIL random_ideal[%0d]: x=%0d got %0d expected %f +/-32", i, in_x[i], out_ln[i], ideal);
            end
        end
    endtask

    task automatic test_reset_midstream;
        clear_q();
        for (int i = 0; i < P; i++) drive(1'b1, 65536 + i * 1000);
        @(negedge clk);
        rst_n = 1'b0;
        pre_vaild = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 6) @(negedge clk);
        checks++;
        if (out_ln.size() != 0) begin
            errors++;
            $display("FAIL midreset_flush: got %0d outputs expected 0", out_ln.size());
        end
        clear_q();
        drive(1'b1, 131072);
        wait_out(1);
        checks++;
        if (out_ln.size() != 1) begin
            errors++;
            $display("FAIL midreset_count: got %0d outputs expected 1", out_ln.size());
        end
        if (out_ln.size() >= 1) begin
            checks++;
            if (out_cyc[0] - in_cyc[0] != LAT) begin
                errors++;
                $display("FAIL midreset_latency: got %0d cycles expected %0d", out_cyc[0] - in_cyc[0], LAT);
            end
            checks++;
            if (absl(out_ln[0] - 45426) > 4) begin
                errors++;
                $display("FAIL midreset_ln: got %0d expected 45426 +/-4", out_ln[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_back_to_back();
        test_special_points();
        test_zero();
        test_hold();
        test_random_stream();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
